postproc_arbiter: RTL and testbench

POSTPROC_ARBITER -- requirements
Module: postproc_arbiter

---
 rtl/postproc_arbiter.sv | 136 +++++++++++++
 tb/tb_postproc_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/postproc_arbiter.sv
// Arbitrates FMA, divsqrt and conversion results into one postprocessing slot,
// with age-based promotion of Div/Cvt and an extra normalization pass for subnormal divsqrt.
module postproc_arbiter #(
  parameter int TAGW    = 5,
  parameter int MAXWAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Flush,
  input  logic            FmaValid,
  input  logic [TAGW-1:0] FmaTag,
  output logic            FmaReady,
  input  logic            DivValid,
  input  logic            DivSubnorm,
  input  logic [TAGW-1:0] DivTag,
  output logic            DivReady,
  input  logic            CvtValid,
  input  logic [TAGW-1:0] CvtTag,
  output logic            CvtReady,
  input  logic            PostReady,
  output logic            PostValid,
  output logic [2:0]      PostSel,
  output logic            PostPass2,
  output logic [TAGW-1:0] PostTag,
  output logic            Busy
);

  localparam int              AGEW    = $clog2(MAXWAIT + 1);
  localparam logic [AGEW-1:0] AGE_MAX = AGEW'(MAXWAIT);

  typedef enum logic [1:0] {IDLE, P2, OUT} state_e;
  typedef enum logic [1:0] {WIN_NONE, WIN_FMA, WIN_DIV, WIN_CVT} win_e;

  state_e          state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [AGEW-1:0] div_age_q, div_age_d;
  logic [AGEW-1:0] cvt_age_q, cvt_age_d;

  logic can_grant;
  logic div_aged;
  logic cvt_aged;
  win_e win;

  // Winner selection; aged requesters jump ahead of FMA, Div first when both are aged.
  always_comb begin
    can_grant = !reset && !Flush &&
                (state_q == IDLE || (state_q == OUT && PostReady));
    div_aged  = DivValid && (div_age_q == AGE_MAX);
    cvt_aged  = CvtValid && (cvt_age_q == AGE_MAX);
    win       = WIN_NONE;
    if (can_grant) begin
      if (div_aged)      win = WIN_DIV;
      else if (cvt_aged) win = WIN_CVT;
      else if (FmaValid) win = WIN_FMA;
      else if (DivValid) win = WIN_DIV;
      else if (CvtValid) win = WIN_CVT;
    end
  end

  assign FmaReady = (win == WIN_FMA);
  assign DivReady = (win == WIN_DIV);
  assign CvtReady = (win == WIN_CVT);

  // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    tag_d     = tag_q;
    div_age_d = div_age_q;
    cvt_age_d = cvt_age_q;

    if (Flush) begin
      state_d = IDLE;
      sel_d   = '0;
    end else begin
      if (!DivValid || DivReady)   div_age_d = '0;
      else if (div_age_q != AGE_MAX) div_age_d = div_age_q + AGEW'(1);
      if (!CvtValid || CvtReady)   cvt_age_d = '0;
      else if (cvt_age_q != AGE_MAX) cvt_age_d = cvt_age_q + AGEW'(1);

      case (state_q)
        P2:  state_d = OUT;
        OUT: if (PostReady) begin
               state_d = IDLE;
               sel_d   = '0;
             end
        default: ;
      endcase

      // A grant overrides the retire-to-IDLE above, giving back-to-back issue.
      case (win)
        WIN_FMA: begin
          state_d = OUT;
          sel_d   = 3'b001;
          tag_d   = FmaTag;
        end
        WIN_DIV: begin
          state_d = DivSubnorm ? P2 : OUT;
          sel_d   = 3'b010;
          tag_d   = DivTag;
        end
        WIN_CVT: begin
          state_d = OUT;
          sel_d   = 3'b100;
          tag_d   = CvtTag;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      tag_q     <= '0;
      div_age_q <= '0;
      cvt_age_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      tag_q     <= tag_d;
      div_age_q <= div_age_d;
      cvt_age_q <= cvt_age_d;
    end
  end

  assign PostValid = (state_q == OUT);
  assign PostPass2 = (state_q == P2);
  assign PostSel   = sel_q;
  assign PostTag   = tag_q;
  assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_postproc_arbiter.sv
// Directed scenarios plus a randomized run against a cycle-level behavioural model
// of the postprocessing arbiter.
module tb_postproc_arbiter;

  localparam int TAGW    = 5;
  localparam int MAXWAIT = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            Flush;
  logic            FmaValid, DivValid, DivSubnorm, CvtValid;
  logic [TAGW-1:0] FmaTag, DivTag, CvtTag;
  logic            FmaReady, DivReady, CvtReady;
  logic            PostReady;
  logic            PostValid, PostPass2, Busy;
  logic [2:0]      PostSel;
  logic [TAGW-1:0] PostTag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  postproc_arbiter #(.TAGW(TAGW), .MAXWAIT(MAXWAIT)) dut (
    .clk(clk), .reset(reset), .Flush(Flush),
    .FmaValid(FmaValid), .FmaTag(FmaTag), .FmaReady(FmaReady),
    .DivValid(DivValid), .DivSubnorm(DivSubnorm), .DivTag(DivTag), .DivReady(DivReady),
    .CvtValid(CvtValid), .CvtTag(CvtTag), .CvtReady(CvtReady),
    .PostReady(PostReady), .PostValid(PostValid), .PostSel(PostSel),
    .PostPass2(PostPass2), .PostTag(PostTag), .Busy(Busy)
  );

  function automatic logic [2:0] rdy();
    return {CvtReady, DivReady, FmaReady};
  endfunction

  function automatic logic [2:0] vpb();
    return {PostValid, PostPass2, Busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Flush = 0; FmaValid = 0; DivValid = 0; DivSubnorm = 0; CvtValid = 0;
    FmaTag = '0; DivTag = '0; CvtTag = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; PostReady = 1;
    FmaValid = 1; DivValid = 1; CvtValid = 1;
    #1;
    checks++;
    if (rdy() !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", rdy()); end
    tick(); tick();
    checks++;
    if (vpb() !== 3'b000 || PostSel !== 3'b000 || PostTag !== '0) begin
      errors++;
      $display("FAIL reset_state vpb=%b sel=%b tag=%0d exp vpb=000 sel=000 tag=0", vpb(), PostSel, PostTag);
    end
    reset = 0;
    idle_inputs();
  endtask

  task automatic test_fma_single();
    FmaValid = 1; FmaTag = 3; PostReady = 1;
    #1;
    checks++;
    if (rdy() !== 3'b001) begin errors++; $display("FAIL fma_grant got=%b exp=001", rdy()); end
    tick();
    FmaValid = 0;
    checks++;
    if (vpb() !== 3'b101 || PostSel !== 3'b001 || PostTag !== 5'd3) begin
      errors++;
      $display("FAIL fma_out vpb=%b sel=%b tag=%0d exp vpb=101 sel=001 tag=3", vpb(), PostSel, PostTag);
    end
    tick();
    checks++;
    if (vpb() !== 3'b000 || PostSel !== 3'b000) begin
      errors++; $display("FAIL fma_idle vpb=%b sel=%b exp vpb=000 sel=000", vpb(), PostSel);
    end
  endtask

  task automatic test_div_two_pass();
    DivValid = 1; DivSubnorm = 1; DivTag = 7; PostReady = 1;
    #1;
    checks++;
    if (rdy() !== 3'b010) begin errors++; $display("FAIL div_grant got=%b exp=010", rdy()); end
    tick();
    DivValid = 0; DivSubnorm = 0;
    checks++;
    if (vpb() !== 3'b011) begin errors++; $display("FAIL div_pass2 vpb=%b exp=011", vpb()); end
    tick();
    checks++;
    if (vpb() !== 3'b101 || PostSel !== 3'b010 || PostTag !== 5'd7) begin
      errors++;
      $display("FAIL div_out vpb=%b sel=%b tag=%0d exp vpb=101 sel=010 tag=7", vpb(), PostSel, PostTag);
    end
    tick();
    checks++;
    if (vpb() !== 3'b000) begin errors++; $display("FAIL div_idle vpb=%b exp=000", vpb()); end
  endtask

  // Cvt stalls MAXWAIT cycles behind FMA, wins once, then starts aging again from zero.
  task automatic test_aging();
    logic [2:0] exp_sel;
    FmaValid = 1; FmaTag = 1; CvtValid = 1; CvtTag = 2; PostReady = 1;
    for (int i = 0; i < 2 * (MAXWAIT + 1); i++) begin
      exp_sel = ((i % (MAXWAIT + 1)) == MAXWAIT) ? 3'b100 : 3'b001;
      #1;
      checks++;
      if (rdy() !== exp_sel) begin errors++; $display("FAIL aging_ready cyc=%0d got=%b exp=%b", i, rdy(), exp_sel); end
      tick();
      checks++;
      if (PostSel !== exp_sel || PostValid !== 1'b1) begin
        errors++; $display("FAIL aging_sel cyc=%0d sel=%b valid=%b exp sel=%b valid=1", i, PostSel, PostValid, exp_sel);
      end
    end
    FmaValid = 0; CvtValid = 0;
    tick();
  endtask

  task automatic test_backpressure();
    FmaValid = 1; FmaTag = 5; PostReady = 1;
    #1;
    tick();
    PostReady = 0; FmaTag = 9;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (rdy() !== 3'b000 || vpb() !== 3'b101 || PostSel !== 3'b001 || PostTag !== 5'd5) begin
        errors++;
        $display("FAIL stall cyc=%0d rdy=%b vpb=%b sel=%b tag=%0d exp rdy=000 vpb=101 sel=001 tag=5",
                 k, rdy(), vpb(), PostSel, PostTag);
      end
      tick();
    end
    PostReady = 1;
    #1;
    checks++;
    if (rdy() !== 3'b001) begin errors++; $display("FAIL b2b_grant got=%b exp=001", rdy()); end
    tick();
    FmaValid = 0;
    checks++;
    if (vpb() !== 3'b101 || PostTag !== 5'd9) begin
      errors++; $display("FAIL b2b_out vpb=%b tag=%0d exp vpb=101 tag=9", vpb(), PostTag);
    end
    tick();
  endtask

  task automatic test_flush_p2();
    DivValid = 1; DivSubnorm = 1; DivTag = 4; PostReady = 1;
    #1;
    tick();
    DivValid = 0; DivSubnorm = 0; Flush = 1; FmaValid = 1;
    #1;
    checks++;
    if (rdy() !== 3'b000) begin errors++; $display("FAIL flush_ready got=%b exp=000", rdy()); end
    tick();
    Flush = 0; FmaValid = 0;
    checks++;
    if (vpb() !== 3'b000 || PostSel !== 3'b000) begin
      errors++; $display("FAIL flush_idle vpb=%b sel=%b exp vpb=000 sel=000", vpb(), PostSel);
    end
    tick();
    checks++;
    if (PostValid !== 1'b0) begin errors++; $display("FAIL flush_no_pulse valid=%b exp=0", PostValid); end
  endtask

  task automatic test_reset_out();
    FmaValid = 1; FmaTag = 6; PostReady = 1;
    #1;
    tick();
    reset = 1; PostReady = 0;
    #1;
    checks++;
    if (rdy() !== 3'b000) begin errors++; $display("FAIL rst_out_ready got=%b exp=000", rdy()); end
    tick();
    reset = 0; FmaValid = 0;
    checks++;
    if (vpb() !== 3'b000 || PostSel !== 3'b000 || PostTag !== '0) begin
      errors++;
      $display("FAIL rst_out_state vpb=%b sel=%b tag=%0d exp vpb=000 sel=000 tag=0", vpb(), PostSel, PostTag);
    end
    tick();
    checks++;
    if (PostValid !== 1'b0) begin errors++; $display("FAIL rst_out_no_pulse valid=%b exp=0", PostValid); end
    PostReady = 1;
  endtask

  // Model: one result slot that is either empty, waiting one extra pass, or presenting.
  task automatic test_random();
    int         div_age, cvt_age, w, shown;
    bit         m_valid, m_pass;
    logic [2:0] m_sel, exp_rdy;
    logic [TAGW-1:0] m_tag;
    bit         accepting;
    reset = 1; idle_inputs(); PostReady = 1;
    tick();
    reset = 0;
    div_age = 0; cvt_age = 0; m_valid = 0; m_pass = 0; m_sel = '0; m_tag = '0;
    shown = 0;
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(63) == 0);
      Flush      = ($urandom_range(15) == 0);
      FmaValid   = $urandom_range(1);
      DivValid   = $urandom_range(1);
      DivSubnorm = $urandom_range(1);
      CvtValid   = $urandom_range(1);
      FmaTag     = TAGW'($urandom);
      DivTag     = TAGW'($urandom);
      CvtTag     = TAGW'($urandom);
      PostReady  = ($urandom_range(3) != 0);
      #1;
      accepting = !reset && !Flush && ((!m_valid && !m_pass) || (m_valid && PostReady));
      w = -1;
      if (accepting) begin
        if (DivValid && div_age == MAXWAIT)      w = 1;
        else if (CvtValid && cvt_age == MAXWAIT) w = 2;
        else if (FmaValid)                       w = 0;
        else if (DivValid)                       w = 1;
        else if (CvtValid)                       w = 2;
      end
      exp_rdy = (w < 0) ? 3'b000 : 3'(1 << w);
      checks++;
      if (rdy() !== exp_rdy) begin
        errors++;
        if (shown++ < 20) $display("FAIL rand_ready cyc=%0d got=%b exp=%b", n, rdy(), exp_rdy);
      end
      tick();
      if (reset) begin
        div_age = 0; cvt_age = 0; m_valid = 0; m_pass = 0; m_sel = '0; m_tag = '0;
      end else if (Flush) begin
        m_valid = 0; m_pass = 0; m_sel = '0;
      end else begin
        div_age = (!DivValid || w == 1) ? 0 : (div_age < MAXWAIT ? div_age + 1 : MAXWAIT);
        cvt_age = (!CvtValid || w == 2) ? 0 : (cvt_age < MAXWAIT ? cvt_age + 1 : MAXWAIT);
        if (w >= 0) begin
          m_sel   = 3'(1 << w);
          m_tag   = (w == 0) ? FmaTag : (w == 1) ? DivTag : CvtTag;
          m_pass  = (w == 1) && DivSubnorm;
          m_valid = !m_pass;
        end else if (m_pass) begin
          m_pass = 0; m_valid = 1;
        end else if (m_valid && PostReady) begin
          m_valid = 0; m_sel = '0;
        end
      end
      checks++;
      if (vpb() !== {m_valid, m_pass, m_valid || m_pass} || PostSel !== m_sel || PostTag !== m_tag) begin
        errors++;
        if (shown++ < 20)
          $display("FAIL rand_out cyc=%0d vpb=%b sel=%b tag=%0d exp vpb=%b sel=%b tag=%0d", n, vpb(), PostSel,
                   PostTag, {m_valid, m_pass, m_valid || m_pass}, m_sel, m_tag);
      end
    end
    reset = 0; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fma_single();
    test_div_two_pass();
    test_aging();
    test_backpressure();
    test_flush_p2();
    test_reset_out();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
